color_seq_tx: RTL and testbench

- Transmit side of the colour-line interface: takes queued colour commands (colour code plus hold length) over a valid/ready handshake.
- Drives one-hot red/green/blue lines for the requested number of cycles, then returns to white when idle.
- Produces the stimulus the colour-change detector consumes, with a registered change strobe for self-checking.

---
 rtl/color_pkg.sv | 29 ++
 rtl/hold_counter.sv | 32 +++
 rtl/color_seq_tx.sv | 160 ++++++++++++++++
 tb/tb_color_seq_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared definitions for the colour-line transmitter: colour codes, FSM states and the
// colour-code to one-hot {red,green,blue} decode.
package color_pkg;

  localparam logic [1:0] WHITE = 2'b00;
  localparam logic [1:0] RED   = 2'b01;
  localparam logic [1:0] GREEN = 2'b10;
  localparam logic [1:0] BLUE  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } state_e;

  // Returns {red, green, blue}; white is all zero.
  function automatic logic [2:0] color_onehot(input logic [1:0] code);
    logic [2:0] lines;
    lines = 3'b000;
    case (code)
      RED:     lines = 3'b100;
      GREEN:   lines = 3'b010;
      BLUE:    lines = 3'b001;
      default: lines = 3'b000;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter used for both the colour hold and the inter-colour gap.
// Decrements saturate at zero so the count can never wrap.
module hold_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Terminal-count flag, decoded from the register.
  always_comb begin
    is_one = (cnt_q == CNT_W'(1));
  end

endmodule

// File: rtl/color_seq_tx.sv
// Colour-line transmitter: accepts {colour, hold} commands over valid/ready and drives
// registered one-hot red/green/blue lines for the requested number of cycles.
// Optional build macro COLOR_TX_GAP_EN inserts GAP_CYCLES white cycles between two
// different non-white colours.
module color_seq_tx
  import color_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_color,
  input  logic [CNT_W-1:0] cmd_hold,
  output logic             red,
  output logic             green,
  output logic             blue,
  output logic             color_change,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       color_q, color_d;
  logic [2:0]       lines_q, lines_d;
  logic             change_q;
  logic             accept;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] hold_eff;

  // A hold of zero behaves as one cycle.
  assign hold_eff = (cmd_hold == '0) ? CNT_W'(1) : cmd_hold;
  assign accept   = cmd_valid & cmd_ready;

`ifdef COLOR_TX_GAP_EN
  localparam logic [CNT_W-1:0] GapLoad = CNT_W'(GAP_CYCLES);

  logic [1:0]       pend_color_q, pend_color_d;
  logic [CNT_W-1:0] pend_hold_q, pend_hold_d;

  // Command parked while the gap runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_color_q <= WHITE;
      pend_hold_q  <= '0;
    end else begin
      pend_color_q <= pend_color_d;
      pend_hold_q  <= pend_hold_d;
    end
  end
`else
  logic unused_gap_cfg;
  assign unused_gap_cfg = ^GAP_CYCLES;
`endif

  hold_counter #(
    .CNT_W (CNT_W)
  ) u_hold_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .is_one   (cnt_is_one)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      color_q <= WHITE;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_d      = state_q;
    color_d      = color_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = hold_eff;
`ifdef COLOR_TX_GAP_EN
    pend_color_d = pend_color_q;
    pend_hold_d  = pend_hold_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StDrive;
          color_d  = cmd_color;
          cnt_load = 1'b1;
        end
      end
      StDrive: begin
        if (!cnt_is_one) begin
          cnt_dec = 1'b1;
        end else if (accept) begin
          cnt_load = 1'b1;
          color_d  = cmd_color;
`ifdef COLOR_TX_GAP_EN
          // Two different real colours get a white gap between them.
          if ((color_q != WHITE) && (cmd_color != WHITE) && (cmd_color != color_q)) begin
            state_d      = StGap;
            pend_color_d = cmd_color;
            pend_hold_d  = hold_eff;
            cnt_load_val = GapLoad;
          end
`endif
        end else begin
          state_d = StIdle;
          color_d = WHITE;
        end
      end
      StGap: begin
`ifdef COLOR_TX_GAP_EN
        if (cnt_is_one) begin
          state_d      = StDrive;
          color_d      = pend_color_q;
          cnt_load     = 1'b1;
          cnt_load_val = pend_hold_q;
        end else begin
          cnt_dec = 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: handshake and busy from registered state, next line value for the registers.
  always_comb begin
    cmd_ready = (state_q == StIdle) || ((state_q == StDrive) && cnt_is_one);
    busy      = (state_q != StIdle);
    lines_d   = (state_d == StDrive) ? color_onehot(color_d) : 3'b000;
  end

  // Registered colour lines and change strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lines_q  <= 3'b000;
      change_q <= 1'b0;
    end else begin
      lines_q  <= lines_d;
      change_q <= (lines_d != lines_q);
    end
  end

  assign red          = lines_q[2];
  assign green        = lines_q[1];
  assign blue         = lines_q[0];
  assign color_change = change_q;

endmodule

// File: tb/tb_color_seq_tx.sv
// Directed bench for color_seq_tx; expected values are hand-derived per cycle.
module tb_color_seq_tx;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_color;
  logic [CNT_W-1:0] cmd_hold;
  logic             red, green, blue;
  logic             color_change;
  logic             busy;

  int checks = 0;
  int errors = 0;

  color_seq_tx #(
    .CNT_W      (CNT_W),
    .GAP_CYCLES (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_color    (cmd_color),
    .cmd_hold     (cmd_hold),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .color_change (color_change),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lines, strobe, busy, ready packed as {rgb, cc, busy, ready}
  task automatic chk_all(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, red, green, blue, color_change, busy, cmd_ready}, {26'd0, exp});
  endtask

  task automatic send(input logic [1:0] c, input logic [CNT_W-1:0] h);
    cmd_valid = 1'b1;
    cmd_color = c;
    cmd_hold  = h;
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_color = 2'b00;
    cmd_hold  = '0;
    step();
    step();
    chk("reset_lines", {29'd0, red, green, blue}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    step();
    chk_all("idle_after_reset", 6'b000_001);

    // Single red hold 3
    send(2'b01, 8'd3);
    step();
    cmd_valid = 1'b0;
    chk_all("red_c1", 6'b100_110);
    step();
    chk_all("red_c2", 6'b100_010);
    step();
    chk_all("red_c3", 6'b100_011);
    step();
    chk_all("red_end", 6'b000_101);
    step();
    chk_all("red_idle", 6'b000_001);

    // Green hold 2 twice, valid held: 4 contiguous cycles, one strobe
    send(2'b10, 8'd2);
    step();
    chk_all("grn_c1", 6'b010_110);
    step();
    chk_all("grn_c2", 6'b010_011);
    step();
    chk_all("grn_c3", 6'b010_010);
    cmd_valid = 1'b0;
    step();
    chk_all("grn_c4", 6'b010_011);
    step();
    chk_all("grn_end", 6'b000_101);

    // Blue hold 0 behaves as 1
    send(2'b11, 8'd0);
    step();
    cmd_valid = 1'b0;
    chk_all("blu0_c1", 6'b001_111);
    step();
    chk_all("blu0_end", 6'b000_101);
    step();

`ifdef COLOR_TX_GAP_EN
    // Red 2 then green 2 with a two-cycle white gap
    send(2'b01, 8'd2);
    step();
    send(2'b10, 8'd2);
    chk_all("gap_r1", 6'b100_110);
    step();
    chk_all("gap_r2", 6'b100_011);
    step();
    cmd_valid = 1'b0;
    chk_all("gap_w1", 6'b000_110);
    step();
    chk_all("gap_w2", 6'b000_010);
    step();
    chk_all("gap_g1", 6'b010_110);
    step();
    chk_all("gap_g2", 6'b010_011);
    step();
    chk_all("gap_end", 6'b000_101);
`else
    // Red 4, blue 5 waiting with valid held: ready only in red's last cycle, no bubble
    send(2'b01, 8'd4);
    step();
    send(2'b11, 8'd5);
    chk_all("hs_r1", 6'b100_110);
    step();
    chk_all("hs_r2", 6'b100_010);
    step();
    chk_all("hs_r3", 6'b100_010);
    step();
    chk_all("hs_r4", 6'b100_011);
    step();
    cmd_valid = 1'b0;
    chk_all("hs_b1", 6'b001_110);
    step();
    step();
    step();
    step();
    chk_all("hs_b5", 6'b001_011);
    step();
    chk_all("hs_end", 6'b000_101);
`endif
    step();

    // White delay command from idle
    send(2'b00, 8'd3);
    step();
    cmd_valid = 1'b0;
    chk_all("wht_c1", 6'b000_010);
    step();
    chk_all("wht_c2", 6'b000_010);
    step();
    chk_all("wht_c3", 6'b000_011);
    step();
    chk_all("wht_end", 6'b000_001);

    // Reset mid-hold of red 10
    send(2'b01, 8'd10);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    chk_all("pre_rst", 6'b100_010);
    reset_n = 1'b0;
    #1;
    chk("rst_async_lines", {29'd0, red, green, blue}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_cc", {31'd0, color_change}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk_all("rst_release", 6'b000_001);
    step();
    chk_all("rst_stays_idle", 6'b000_001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
